lif_layer_seq: RTL and testbench

LIF_LAYER_SEQ -- requirements
Module: lif_layer_seq

---
 rtl/lif_layer_seq.sv | 246 ++++++++++++++++++++++++
 tb/tb_lif_layer_seq.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lif_layer_seq.sv
// lif_layer_seq: time-multiplexed layer of leaky integrate-and-fire neurons.
//
// One timestep walks every neuron in turn. For each neuron the shared weight
// store is read once per input, the weights of active inputs are summed, and a
// single update cycle applies refractory, saturating integration, leak and
// threshold. When all neurons are done the spike vector is published.
//
// Ports:
//   clk, rst              clock (rising edge), asynchronous active-low reset
//   step_valid/step_ready handshake starting one timestep; spike_in sampled on accept
//   spike_in              input spike vector
//   clear_state           in IDLE, clears potentials, refractory counters, spiked flags
//   spike_out/spike_valid spike vector of the last step, one-cycle valid pulse
//   busy                  high while a step is in progress
//   mem_addr/mem_din/
//   mem_wen/mem_dout      host access to the weight store ({neuron, input} address)
module lif_layer_seq #(
  parameter int unsigned                 WEIGHT_SIZE       = 32,
  parameter int unsigned                 POT_SIZE          = 2 * WEIGHT_SIZE,
  parameter logic signed [POT_SIZE-1:0]  THRESH            = POT_SIZE'(15),
  parameter logic signed [POT_SIZE-1:0]  RESET             = '0,
  parameter logic signed [POT_SIZE-1:0]  LEAK              = '0,
  parameter int unsigned                 REFRAC            = 5,
  parameter int unsigned                 NUM_INPUTS        = 4,
  parameter int unsigned                 NUM_NEURONS       = 1,
  parameter int unsigned                 SINGLE_SPIKE      = 0,
  parameter int unsigned                 WEIGHT_ADDR_WIDTH = 10,
  parameter int unsigned                 NEURON_ADDR_WIDTH = 28
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         step_valid,
  output logic                         step_ready,
  input  logic [NUM_INPUTS-1:0]        spike_in,
  input  logic                         clear_state,
  output logic [NUM_NEURONS-1:0]       spike_out,
  output logic                         spike_valid,
  output logic                         busy,
  input  logic [NEURON_ADDR_WIDTH-1:0] mem_addr,
  input  logic [WEIGHT_SIZE-1:0]       mem_din,
  input  logic                         mem_wen,
  output logic [WEIGHT_SIZE-1:0]       mem_dout
);

  localparam int unsigned DEPTH = NUM_NEURONS * NUM_INPUTS;
  localparam int unsigned MAW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned NW    = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
  localparam int unsigned KW    = $clog2(NUM_INPUTS + 1);
  localparam int unsigned RW    = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;
  localparam int unsigned NIW   = NEURON_ADDR_WIDTH - WEIGHT_ADDR_WIDTH;

  localparam logic [KW-1:0] KLast = KW'(NUM_INPUTS);
  localparam logic [NW-1:0] NLast = NW'(NUM_NEURONS - 1);

  localparam logic signed [POT_SIZE-1:0] PotMax = {1'b0, {(POT_SIZE - 1){1'b1}}};
  localparam logic signed [POT_SIZE-1:0] PotMin = {1'b1, {(POT_SIZE - 1){1'b0}}};

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StAccum  = 2'd1;
  localparam logic [1:0] StUpdate = 2'd2;
  localparam logic [1:0] StDone   = 2'd3;

  // Signed add clamped to the potential range.
  function automatic logic signed [POT_SIZE-1:0] sat_add(input logic signed [POT_SIZE-1:0] a,
                                                         input logic signed [POT_SIZE-1:0] b);
    logic [POT_SIZE:0] s;
    s = {a[POT_SIZE-1], a} + {b[POT_SIZE-1], b};
    if (s[POT_SIZE] != s[POT_SIZE-1]) begin
      return s[POT_SIZE] ? PotMin : PotMax;
    end
    return s[POT_SIZE-1:0];
  endfunction

  // Weight store (not reset) and per-neuron state.
  logic [WEIGHT_SIZE-1:0]       mem [DEPTH];
  logic signed [POT_SIZE-1:0]   pot_q [NUM_NEURONS];
  logic [RW-1:0]                ref_q [NUM_NEURONS];
  logic                         spiked_q [NUM_NEURONS];

  logic [1:0]                   state_q, state_d;
  logic [NW-1:0]                n_q;
  logic [KW-1:0]                k_q;
  logic signed [POT_SIZE-1:0]   acc_q;
  logic [WEIGHT_SIZE-1:0]       w_rd_q;
  logic                         hit_q;
  logic [NUM_INPUTS-1:0]        spike_in_q;
  logic [NUM_NEURONS-1:0]       spike_vec_q;
  logic [NUM_NEURONS-1:0]       spike_out_q;
  logic                         spike_valid_q;
  logic [WEIGHT_SIZE-1:0]       mem_dout_q;

  assign busy        = (state_q != StIdle);
  assign step_ready  = (state_q == StIdle) && !clear_state;
  assign spike_out   = spike_out_q;
  assign spike_valid = spike_valid_q;
  assign mem_dout    = mem_dout_q;

  // Host address decode.
  logic [NIW-1:0]               h_neuron;
  logic [WEIGHT_ADDR_WIDTH-1:0] h_input;
  logic                         h_ok;
  logic [MAW-1:0]               h_idx;

  always_comb begin
    h_neuron = mem_addr[NEURON_ADDR_WIDTH-1:WEIGHT_ADDR_WIDTH];
    h_input  = mem_addr[WEIGHT_ADDR_WIDTH-1:0];
    h_ok     = (32'(h_neuron) < NUM_NEURONS) && (32'(h_input) < NUM_INPUTS);
    h_idx    = MAW'(32'(h_neuron) * NUM_INPUTS + 32'(h_input));
  end

  // Internal read port used during ACCUM. k_q == KLast is the drain cycle
  // where the last read's data is summed and no new read is issued.
  logic [MAW-1:0]            rd_idx;
  logic                      rd_ok;
  logic [NUM_INPUTS-1:0]     spike_sh;
  logic signed [POT_SIZE-1:0] w_ext;

  always_comb begin
    rd_idx   = MAW'(32'(n_q) * NUM_INPUTS + 32'(k_q));
    rd_ok    = (k_q != KLast);
    spike_sh = spike_in_q >> k_q;
    w_ext    = {{(POT_SIZE - WEIGHT_SIZE){w_rd_q[WEIGHT_SIZE-1]}}, w_rd_q};
  end

  // Neuron update for the neuron currently selected by n_q.
  logic signed [POT_SIZE-1:0] cur_pot, integ, leaked, upd_pot;
  logic signed [POT_SIZE:0]   integ_w, leak_lim;
  logic [RW-1:0]              cur_ref, upd_ref;
  logic                       cur_spk, upd_spk, upd_fire, can_fire;

  always_comb begin
    cur_pot  = pot_q[n_q];
    cur_ref  = ref_q[n_q];
    cur_spk  = spiked_q[n_q];
    integ    = sat_add(cur_pot, acc_q);
    integ_w  = {integ[POT_SIZE-1], integ};
    // RESET+LEAK formed one bit wider so the comparison cannot overflow.
    leak_lim = {RESET[POT_SIZE-1], RESET} + {LEAK[POT_SIZE-1], LEAK};
    if (integ_w > leak_lim) begin
      leaked = integ - LEAK;
    end else if (integ > RESET) begin
      leaked = RESET;
    end else begin
      leaked = integ;
    end
    can_fire = (leaked >= THRESH) && !((SINGLE_SPIKE != 0) && cur_spk);

    upd_pot  = leaked;
    upd_ref  = '0;
    upd_spk  = cur_spk;
    upd_fire = 1'b0;
    if (cur_ref != '0) begin
      upd_pot = RESET;
      upd_ref = cur_ref - 1'b1;
    end else if (can_fire) begin
      upd_pot  = RESET;
      upd_ref  = RW'(REFRAC);
      upd_spk  = 1'b1;
      upd_fire = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (step_ready && step_valid) state_d = StAccum;
      StAccum:  if (k_q == KLast) state_d = StUpdate;
      StUpdate: state_d = (n_q == NLast) ? StDone : StAccum;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (mem_wen && !busy && h_ok) begin
      mem[h_idx] <= mem_din;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= StIdle;
      n_q           <= '0;
      k_q           <= '0;
      acc_q         <= '0;
      w_rd_q        <= '0;
      hit_q         <= 1'b0;
      spike_in_q    <= '0;
      spike_vec_q   <= '0;
      spike_out_q   <= '0;
      spike_valid_q <= 1'b0;
      mem_dout_q    <= '0;
      for (int j = 0; j < int'(NUM_NEURONS); j++) begin
        pot_q[j]    <= RESET;
        ref_q[j]    <= '0;
        spiked_q[j] <= 1'b0;
      end
    end else begin
      state_q       <= state_d;
      spike_valid_q <= (state_q == StDone);
      mem_dout_q    <= (!busy && h_ok) ? mem[h_idx] : '0;
      case (state_q)
        StIdle: begin
          if (clear_state) begin
            for (int j = 0; j < int'(NUM_NEURONS); j++) begin
              pot_q[j]    <= RESET;
              ref_q[j]    <= '0;
              spiked_q[j] <= 1'b0;
            end
          end else if (step_valid) begin
            spike_in_q  <= spike_in;
            n_q         <= '0;
            k_q         <= '0;
            acc_q       <= '0;
            spike_vec_q <= '0;
          end
        end
        StAccum: begin
          k_q    <= k_q + 1'b1;
          w_rd_q <= rd_ok ? mem[rd_idx] : '0;
          hit_q  <= rd_ok && spike_sh[0];
          // Data read in the previous cycle arrives now.
          if ((k_q != '0) && hit_q) begin
            acc_q <= sat_add(acc_q, w_ext);
          end
        end
        StUpdate: begin
          pot_q[n_q]       <= upd_pot;
          ref_q[n_q]       <= upd_ref;
          spiked_q[n_q]    <= upd_spk;
          spike_vec_q[n_q] <= upd_fire;
          if (n_q != NLast) begin
            n_q   <= n_q + 1'b1;
            k_q   <= '0;
            acc_q <= '0;
          end
        end
        StDone: begin
          spike_out_q <= spike_vec_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lif_layer_seq.sv
// Bench for lif_layer_seq. Two instances share all inputs: dut_a uses LEAK=0,
// SINGLE_SPIKE=0; dut_b uses LEAK=1, SINGLE_SPIKE=1. Both are 8-bit weights,
// 4 inputs, 2 neurons, THRESH=15, REFRAC=2. A behavioural model tracks both.
module tb_lif_layer_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        step_valid = 1'b0;
  logic        clear_state = 1'b0;
  logic        mem_wen = 1'b0;
  logic [3:0]  spike_in = '0;
  logic [27:0] mem_addr = '0;
  logic [7:0]  mem_din = '0;

  logic       rdy_a, sv_a, busy_a, rdy_b, sv_b, busy_b;
  logic [1:0] so_a, so_b;
  logic [7:0] dout_a, dout_b;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: weights (flat neuron*4+input), potentials, refractory, flags.
  int mw [8];
  int mpot [2][2];
  int mref [2][2];
  bit mspk [2][2];

  always #5 clk = ~clk;

  lif_layer_seq #(
    .WEIGHT_SIZE(8), .THRESH(16'sd15), .RESET(16'sd0), .LEAK(16'sd0), .REFRAC(2),
    .NUM_INPUTS(4), .NUM_NEURONS(2), .SINGLE_SPIKE(0)
  ) dut_a (
    .clk(clk), .rst(rst), .step_valid(step_valid), .step_ready(rdy_a), .spike_in(spike_in),
    .clear_state(clear_state), .spike_out(so_a), .spike_valid(sv_a), .busy(busy_a),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_wen(mem_wen), .mem_dout(dout_a)
  );

  lif_layer_seq #(
    .WEIGHT_SIZE(8), .THRESH(16'sd15), .RESET(16'sd0), .LEAK(16'sd1), .REFRAC(2),
    .NUM_INPUTS(4), .NUM_NEURONS(2), .SINGLE_SPIKE(1)
  ) dut_b (
    .clk(clk), .rst(rst), .step_valid(step_valid), .step_ready(rdy_b), .spike_in(spike_in),
    .clear_state(clear_state), .spike_out(so_b), .spike_valid(sv_b), .busy(busy_b),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_wen(mem_wen), .mem_dout(dout_b)
  );

  task automatic model_clear();
    for (int c = 0; c < 2; c++) begin
      for (int n = 0; n < 2; n++) begin
        mpot[c][n] = 0;
        mref[c][n] = 0;
        mspk[c][n] = 1'b0;
      end
    end
  endtask

  task automatic model_step(input logic [3:0] si, output logic [1:0] ea, output logic [1:0] eb);
    logic [1:0] so [2];
    int acc, p, lk;
    so[0] = '0;
    so[1] = '0;
    for (int c = 0; c < 2; c++) begin
      lk = (c == 1) ? 1 : 0;
      for (int n = 0; n < 2; n++) begin
        acc = 0;
        for (int i = 0; i < 4; i++) if (si[i]) acc += mw[n*4+i];
        if (mref[c][n] > 0) begin
          mref[c][n]--;
          mpot[c][n] = 0;
        end else begin
          p = mpot[c][n] + acc;
          if (p > 32767) p = 32767;
          if (p < -32768) p = -32768;
          if (p > lk) p -= lk;
          else if (p > 0) p = 0;
          if (p >= 15 && !(c == 1 && mspk[c][n])) begin
            mpot[c][n] = 0;
            mref[c][n] = 2;
            mspk[c][n] = 1'b1;
            so[c][n]   = 1'b1;
          end else begin
            mpot[c][n] = p;
          end
        end
      end
    end
    ea = so[0];
    eb = so[1];
  endtask

  task automatic write_w(input int n, input int i, input int val);
    @(negedge clk);
    mem_addr = {18'(n), 10'(i)};
    mem_din  = 8'(val);
    mem_wen  = 1'b1;
    @(posedge clk);
    #1 mem_wen = 1'b0;
    if (n < 2 && i < 4) mw[n*4+i] = val;
  endtask

  task automatic read_check(input int n, input int i);
    logic [7:0] exp;
    @(negedge clk);
    mem_addr = {18'(n), 10'(i)};
    @(posedge clk);
    #1;
    exp = (n < 2 && i < 4) ? 8'(mw[n*4+i]) : 8'h00;
    n_checks++;
    if (dout_a !== exp || dout_b !== exp) begin
      n_errors++;
      $display("FAIL readback n%0d i%0d: got a=%h b=%h, want %h", n, i, dout_a, dout_b, exp);
    end
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear_state = 1'b1;
    step_valid  = 1'b1;
    #1;
    n_checks++;
    if (rdy_a !== 1'b0 || rdy_b !== 1'b0) begin
      n_errors++;
      $display("FAIL clear_ready: got a=%b b=%b, want 0", rdy_a, rdy_b);
    end
    @(posedge clk);
    #1;
    clear_state = 1'b0;
    step_valid  = 1'b0;
    n_checks++;
    if (busy_a !== 1'b0 || busy_b !== 1'b0) begin
      n_errors++;
      $display("FAIL clear_no_accept: busy a=%b b=%b, want 0", busy_a, busy_b);
    end
    model_clear();
  endtask

  task automatic do_step(input logic [3:0] si, output logic [1:0] ga, output logic [1:0] gb);
    logic [1:0] ea, eb;
    int lat;
    bit got;
    @(negedge clk);
    n_checks++;
    if (rdy_a !== 1'b1 || rdy_b !== 1'b1) begin
      n_errors++;
      $display("FAIL step_ready: got a=%b b=%b, want 1", rdy_a, rdy_b);
    end
    spike_in   = si;
    step_valid = 1'b1;
    @(posedge clk);
    #1;
    step_valid = 1'b0;
    spike_in   = 4'($urandom);
    model_step(si, ea, eb);
    n_checks++;
    if (busy_a !== 1'b1 || busy_b !== 1'b1) begin
      n_errors++;
      $display("FAIL busy_after_accept: got a=%b b=%b, want 1", busy_a, busy_b);
    end
    lat = 0;
    got = 1'b0;
    while (!got && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == 5) begin
        n_checks++;
        if (dout_a !== 8'h00 || dout_b !== 8'h00) begin
          n_errors++;
          $display("FAIL dout_busy: got a=%h b=%h, want 00", dout_a, dout_b);
        end
      end
      if (lat == 12) begin
        n_checks++;
        if (busy_a !== 1'b1 || busy_b !== 1'b1) begin
          n_errors++;
          $display("FAIL busy_in_done: got a=%b b=%b, want 1", busy_a, busy_b);
        end
      end
      if (sv_a === 1'b1) got = 1'b1;
    end
    n_checks++;
    if (!got || lat != 13) begin
      n_errors++;
      $display("FAIL latency: got %0d (seen=%0d), want 13", lat, got);
    end
    n_checks++;
    if (sv_b !== 1'b1 || busy_a !== 1'b0 || busy_b !== 1'b0) begin
      n_errors++;
      $display("FAIL valid_busy: got sv_b=%b busy a=%b b=%b, want 1 0 0", sv_b, busy_a, busy_b);
    end
    n_checks++;
    if (so_a !== ea || so_b !== eb) begin
      n_errors++;
      $display("FAIL spike_out si=%b: got a=%b b=%b, want a=%b b=%b", si, so_a, so_b, ea, eb);
    end
    ga = so_a;
    gb = so_b;
    @(posedge clk);
    #1;
    n_checks++;
    if (sv_a !== 1'b0 || sv_b !== 1'b0 || so_a !== ea || so_b !== eb) begin
      n_errors++;
      $display("FAIL valid_pulse: got sv a=%b b=%b so a=%b b=%b, want 0 0 %b %b",
               sv_a, sv_b, so_a, so_b, ea, eb);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (so_a !== 2'b00 || sv_a !== 1'b0 || busy_a !== 1'b0 || dout_a !== 8'h00 ||
        so_b !== 2'b00 || sv_b !== 1'b0 || busy_b !== 1'b0 || dout_b !== 8'h00) begin
      n_errors++;
      $display("FAIL reset_outputs: got so=%b/%b sv=%b/%b busy=%b/%b dout=%h/%h, want zeros",
               so_a, so_b, sv_a, sv_b, busy_a, busy_b, dout_a, dout_b);
    end
    @(negedge clk);
    rst = 1'b1;
    model_clear();
    @(negedge clk);
    n_checks++;
    if (rdy_a !== 1'b1 || rdy_b !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_ready: got a=%b b=%b, want 1", rdy_a, rdy_b);
    end
  endtask

  task automatic test_basic();
    logic [1:0] ga, gb;
    logic [1:0] exp_a [4];
    exp_a = '{2'b01, 2'b00, 2'b00, 2'b11};
    do_clear();
    for (int i = 0; i < 4; i++) begin
      write_w(0, i, 4);
      write_w(1, i, 1);
    end
    for (int s = 0; s < 4; s++) begin
      do_step(4'b1111, ga, gb);
      n_checks++;
      if (ga !== exp_a[s]) begin
        n_errors++;
        $display("FAIL basic_step%0d: got %b, want %b", s + 1, ga, exp_a[s]);
      end
    end
  endtask

  task automatic test_leak();
    logic [1:0] ga, gb;
    do_clear();
    for (int k = 0; k < 8; k++) write_w(k / 4, k % 4, 0);
    write_w(0, 0, 5);
    for (int s = 0; s < 4; s++) begin
      do_step(4'b0001, ga, gb);
      n_checks++;
      if (gb[0] !== ((s == 3) ? 1'b1 : 1'b0)) begin
        n_errors++;
        $display("FAIL leak_step%0d: got %b, want %b", s + 1, gb[0], (s == 3));
      end
    end
  endtask

  task automatic test_single_spike();
    logic [1:0] ga, gb;
    int cnt;
    do_clear();
    for (int i = 0; i < 4; i++) begin
      write_w(0, i, 4);
      write_w(1, i, 1);
    end
    cnt = 0;
    for (int s = 0; s < 6; s++) begin
      do_step(4'b1111, ga, gb);
      if (gb[0] === 1'b1) cnt++;
    end
    n_checks++;
    if (cnt != 1) begin
      n_errors++;
      $display("FAIL single_spike_count: got %0d, want 1", cnt);
    end
    do_clear();
    do_step(4'b1111, ga, gb);
    n_checks++;
    if (gb[0] !== 1'b1) begin
      n_errors++;
      $display("FAIL single_spike_after_clear: got %b, want 1", gb[0]);
    end
  endtask

  task automatic test_saturation();
    logic [1:0] ga, gb;
    int fa, fb;
    do_clear();
    for (int k = 0; k < 8; k++) write_w(k / 4, k % 4, -128);
    for (int s = 0; s < 300; s++) do_step(4'b1111, ga, gb);
    for (int k = 0; k < 8; k++) write_w(k / 4, k % 4, 127);
    fa = 0;
    fb = 0;
    for (int s = 1; s <= 66; s++) begin
      do_step(4'b1111, ga, gb);
      if (fa == 0 && ga[0] === 1'b1) fa = s;
      if (fb == 0 && gb[0] === 1'b1) fb = s;
    end
    n_checks++;
    if (fa != 65 || fb != 65) begin
      n_errors++;
      $display("FAIL saturation_recovery: first spike a=%0d b=%0d, want 65", fa, fb);
    end
  endtask

  task automatic test_random();
    logic [1:0] ga, gb;
    for (int s = 0; s < 30; s++) begin
      if (s % 5 == 0) begin
        for (int k = 0; k < 8; k++) write_w(k / 4, k % 4, int'($urandom_range(255)) - 128);
      end
      if ($urandom_range(9) == 0) do_clear();
      do_step(4'($urandom), ga, gb);
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    for (int k = 0; k < 8; k++) write_w(k / 4, k % 4, int'($urandom_range(255)) - 128);
    @(negedge clk);
    spike_in   = 4'b1111;
    step_valid = 1'b1;
    @(posedge clk);
    #1 step_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    n_checks++;
    if (busy_a !== 1'b0 || busy_b !== 1'b0 || sv_a !== 1'b0 || sv_b !== 1'b0 ||
        so_a !== 2'b00 || so_b !== 2'b00 || dout_a !== 8'h00 || dout_b !== 8'h00) begin
      n_errors++;
      $display("FAIL async_reset: got busy=%b/%b sv=%b/%b so=%b/%b dout=%h/%h, want zeros",
               busy_a, busy_b, sv_a, sv_b, so_a, so_b, dout_a, dout_b);
    end
    model_clear();
    @(negedge clk);
    rst  = 1'b1;
    seen = 1'b0;
    repeat (25) begin
      @(posedge clk);
      #1;
      if (sv_a === 1'b1 || sv_b === 1'b1) seen = 1'b1;
    end
    n_checks++;
    if (seen) begin
      n_errors++;
      $display("FAIL abort_no_valid: got spike_valid=1, want none");
    end
    for (int k = 0; k < 8; k++) read_check(k / 4, k % 4);
  endtask

  task automatic test_busy_write();
    logic [1:0] ea, eb;
    int lat;
    bit got;
    @(negedge clk);
    spike_in   = 4'b0101;
    step_valid = 1'b1;
    @(posedge clk);
    #1;
    step_valid = 1'b0;
    model_step(4'b0101, ea, eb);
    mem_addr = {18'd0, 10'd0};
    mem_din  = ~8'(mw[0]);
    mem_wen  = 1'b1;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (sv_a === 1'b1) got = 1'b1;
    end
    mem_wen = 1'b0;
    n_checks++;
    if (!got || so_a !== ea || so_b !== eb) begin
      n_errors++;
      $display("FAIL busy_write_step: got seen=%0d so=%b/%b, want 1 %b/%b", got, so_a, so_b,
               ea, eb);
    end
    read_check(0, 0);
    write_w(2, 1, 55);
    read_check(2, 1);
    read_check(0, 1);
  endtask

  initial begin
    for (int k = 0; k < 8; k++) mw[k] = 0;
    model_clear();
    test_reset();
    test_basic();
    test_leak();
    test_single_spike();
    test_saturation();
    test_random();
    test_reset_mid();
    test_busy_write();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
